// File: rtl/modular_addsub_ctrl_if.sv
// Handshake and operand bus between the modular add/sub sequencer and the wide multi-cycle adder.
interface modular_addsub_ctrl_if #(
  parameter int unsigned WIDTH = 1027
) ();
  logic             add_start;
  logic             add_subtract;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_result;
  logic             add_done;

  modport master (
    output add_start,
    output add_subtract,
    output add_a,
    output add_b,
    input  add_result,
    input  add_done
  );

  modport slave (
    input  add_start,
    input  add_subtract,
    input  add_a,
    input  add_b,
    output add_result,
    output add_done
  );
endinterface

// File: rtl/modular_addsub_ctrl.sv
// Modular add/subtract sequencer: R = (A +/- B) mod M using one or two passes
// through the external multi-cycle adder (operation, then +/-M correction).
module modular_addsub_ctrl #(
  parameter int unsigned WIDTH = 1027
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [WIDTH-1:0]      in_m,
  modular_addsub_ctrl_if.master add_if,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    W1   = 3'd2,
    S2   = 3'd3,
    W2   = 3'd4,
    FIN  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic             gap_q, gap_d;
  logic             add_start_q, add_start_d;
  logic             add_sub_q, add_sub_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next state; adder-facing outputs are loaded on entry to S1/S2 so they line up with those states.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    sub_d       = sub_q;
    r1_d        = r1_q;
    gap_d       = 1'b0;
    add_start_d = 1'b0;
    add_sub_d   = add_sub_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    result_d    = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d         = in_m;
          sub_d       = op_sub;
          add_start_d = 1'b1;
          add_a_d     = in_a;
          add_b_d     = in_b;
          add_sub_d   = op_sub;
          state_d     = S1;
        end
      end
      S1: state_d = W1;
      W1: begin
        // gap_q marks the adder's done->idle cycle before the correction op is issued
        if (gap_q) begin
          add_start_d = 1'b1;
          add_a_d     = r1_q;
          add_b_d     = m_q;
          add_sub_d   = ~sub_q;
          state_d     = S2;
        end else if (add_if.add_done) begin
          r1_d = add_if.add_result[WIDTH-1:0];
          if (sub_q && !add_if.add_result[WIDTH]) begin
            result_d = add_if.add_result[WIDTH-1:0];
            state_d  = FIN;
          end else begin
            gap_d = 1'b1;
          end
        end
      end
      S2: state_d = W2;
      W2: begin
        if (add_if.add_done) begin
          if (sub_q || !add_if.add_result[WIDTH]) begin
            result_d = add_if.add_result[WIDTH-1:0];
          end else begin
            result_d = r1_q;
          end
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != FIN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      m_q         <= '0;
      sub_q       <= 1'b0;
      r1_q        <= '0;
      gap_q       <= 1'b0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      sub_q       <= sub_d;
      r1_q        <= r1_d;
      gap_q       <= gap_d;
      add_start_q <= add_start_d;
      add_sub_q   <= add_sub_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign add_if.add_start    = add_start_q;
  assign add_if.add_subtract = add_sub_q;
  assign add_if.add_a        = add_a_q;
  assign add_if.add_b        = add_b_q;
  assign result              = result_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule
